// File: rtl/lut_frac_pkg.sv
// rtl/lut_frac_pkg.sv - shared types and sizing helpers for the fracturable LUT
package lut_frac_pkg;

  // Configuration loader states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } cfg_state_e;

  // Ceiling log2, used only on elaboration-time constants.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Ceiling division.
  function automatic int cdiv_f(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Width of the mode field; never less than one bit.
  function automatic int mode_w_f(input int max_split_log);
    int w;
    w = clog2_f(max_split_log + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Meaningful bits in one configuration image: table, mode, reg_out.
  function automatic int cfg_bits_f(input int inputs, input int max_split_log);
    return (1 << inputs) + mode_w_f(max_split_log) + 1;
  endfunction

  // Number of words streamed per image.
  function automatic int cfg_words_f(input int inputs, input int max_split_log, input int cfg_w);
    return cdiv_f(cfg_bits_f(inputs, max_split_log), cfg_w);
  endfunction

  // Mode field sits directly above the truth table.
  function automatic int mode_lsb_f(input int inputs);
    return 1 << inputs;
  endfunction

  // reg_out sits directly above the mode field.
  function automatic int reg_out_bit_f(input int inputs, input int max_split_log);
    return (1 << inputs) + mode_w_f(max_split_log);
  endfunction

endpackage

// File: rtl/lut_frac_cfg_loader.sv
// rtl/lut_frac_cfg_loader.sv - streams config words into a shadow image and strobes commit
module lut_frac_cfg_loader
  import lut_frac_pkg::*;
#(
  parameter int CFG_W     = 4,
  parameter int CFG_WORDS = 5,
  parameter int CFG_BITS  = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_W-1:0]    cfg_data,
  input  logic                cfg_abort,
  output logic                cfg_done,
  output logic                commit,
  output logic [CFG_BITS-1:0] image
);

  localparam int CNT_W = (CFG_WORDS > 1) ? clog2_f(CFG_WORDS) : 1;

  cfg_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  // Only the meaningful low bits are kept; the zero pad falls off the top.
  logic [CFG_BITS-1:0] shadow_q;
  logic [CFG_BITS-1:0] shifted;
  logic                last_word;
  logic                take;

  assign shifted   = CFG_BITS'({shadow_q, cfg_data});
  assign last_word = (cnt_q == CNT_W'(CFG_WORDS - 1));
  assign take      = cfg_valid && cfg_ready && !cfg_abort;
  assign image     = shifted;
  assign cfg_done  = (state_q == ST_COMMIT);

  // Loader state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state, handshake and commit strobe; abort beats a same-cycle word.
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    commit    = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_abort) begin
          state_d = ST_IDLE;
        end else if (cfg_valid) begin
          if (last_word) begin
            commit  = 1'b1;
            state_d = ST_COMMIT;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Shadow shift register and word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      cnt_q    <= '0;
    end else if (cfg_ready && cfg_abort) begin
      cnt_q <= '0;
    end else if (take) begin
      shadow_q <= shifted;
      cnt_q    <= last_word ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/lut_frac_cfg.sv
// rtl/lut_frac_cfg.sv - fracturable softcoded LUT with atomically committed configuration
module lut_frac_cfg
  import lut_frac_pkg::*;
#(
  parameter int INPUTS        = 4,
  parameter int MAX_SPLIT_LOG = 1,
  parameter int CFG_W         = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [(1<<MAX_SPLIT_LOG)*INPUTS-1:0]  addr,
  output logic [(1<<MAX_SPLIT_LOG)-1:0]         out,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic [CFG_W-1:0]                      cfg_data,
  input  logic                                  cfg_abort,
  output logic                                  cfg_done,
  output logic                                  cfg_err
);

  localparam int NUM_OUT     = 1 << MAX_SPLIT_LOG;
  localparam int TBL_W       = 1 << INPUTS;
  localparam int MODE_W      = mode_w_f(MAX_SPLIT_LOG);
  localparam int CFG_BITS    = cfg_bits_f(INPUTS, MAX_SPLIT_LOG);
  localparam int CFG_WORDS   = cfg_words_f(INPUTS, MAX_SPLIT_LOG, CFG_W);
  localparam int MODE_LSB    = mode_lsb_f(INPUTS);
  localparam int REG_OUT_BIT = reg_out_bit_f(INPUTS, MAX_SPLIT_LOG);

  logic                commit;
  logic [CFG_BITS-1:0] image;
  logic [TBL_W-1:0]    tbl_q;
  logic [MODE_W-1:0]   mode_q;
  logic                reg_out_q;
  logic [NUM_OUT-1:0]  out_raw;
  logic [NUM_OUT-1:0]  out_q;
  logic [INPUTS-1:0]   sel;

  lut_frac_cfg_loader #(
    .CFG_W     (CFG_W),
    .CFG_WORDS (CFG_WORDS),
    .CFG_BITS  (CFG_BITS)
  ) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_abort (cfg_abort),
    .cfg_done  (cfg_done),
    .commit    (commit),
    .image     (image)
  );

  // Active configuration, replaced whole on the commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q     <= '0;
      mode_q    <= '0;
      reg_out_q <= 1'b0;
    end else if (commit) begin
      tbl_q     <= image[TBL_W-1:0];
      mode_q    <= image[MODE_LSB +: MODE_W];
      reg_out_q <= image[REG_OUT_BIT];
    end
  end

  assign cfg_err = (int'(mode_q) > MAX_SPLIT_LOG);

  // Fracture mux: sub-LUT j reads its own slice of the table with the low address bits.
  always_comb begin
    out_raw = '0;
    sel     = '0;
    for (int m = 0; m <= MAX_SPLIT_LOG; m++) begin
      if ((int'(mode_q) == m) || ((m == 0) && cfg_err)) begin
        for (int j = 0; j < NUM_OUT; j++) begin
          if (j < (1 << m)) begin
            sel = INPUTS'(j << (INPUTS - m)) |
                  (addr[j*INPUTS +: INPUTS] & INPUTS'((1 << (INPUTS - m)) - 1));
            out_raw[j] = tbl_q[sel];
          end
        end
      end
    end
  end

  // Output flops run every cycle so a switch to registered mode is never stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_raw;
  end

  assign out = reg_out_q ? out_q : out_raw;

endmodule
